// File: rtl/elevator_pkg.sv
// ----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator call scheduler: building size, floor
// index width, FSM state encoding, travel direction and default door dwell.
// No ports; imported by elevator_call_scheduler and next_floor_select.
// ----------------------------------------------------------------------------
package elevator_pkg;

    localparam int N_FLOORS      = 4;
    localparam int FLOOR_W       = 2;
    localparam int DWELL_DEFAULT = 3;
    // Dwell counter is wide enough for the largest legal dwell (15 cycles).
    localparam int DWELL_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR      = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/next_floor_select.sv
// ----------------------------------------------------------------------------
// next_floor_select
// Purely combinational search for the closest pending floor strictly above
// and strictly below the car's current floor.
// Ports:
//   pending       in  N_FLOORS  latched, not-yet-served calls
//   cur_floor     in  FLOOR_W   floor the car is at now
//   nearest_above out FLOOR_W   lowest pending floor above cur_floor
//   above_valid   out 1         a pending floor above exists
//   nearest_below out FLOOR_W   highest pending floor below cur_floor
//   below_valid   out 1         a pending floor below exists
// ----------------------------------------------------------------------------
module next_floor_select
    import elevator_pkg::*;
(
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  cur_floor,
    output logic [FLOOR_W-1:0]  nearest_above,
    output logic                above_valid,
    output logic [FLOOR_W-1:0]  nearest_below,
    output logic                below_valid
);

    // Scanning top-down for "above" and bottom-up for "below" lets the last
    // hit of each loop be the floor closest to the car.
    always_comb begin
        nearest_above = '0;
        above_valid   = 1'b0;
        nearest_below = '0;
        below_valid   = 1'b0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                nearest_above = FLOOR_W'(i);
                above_valid   = 1'b1;
            end
        end
        for (int j = 0; j < N_FLOORS; j++) begin
            if (pending[j] && (j < int'(cur_floor))) begin
                nearest_below = FLOOR_W'(j);
                below_valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// ----------------------------------------------------------------------------
// elevator_call_scheduler
// Latches floor calls and drives a single car with a collective (SCAN-like)
// policy: keep going in the current direction while calls remain that way,
// open the door for a fixed dwell at each served floor, then reverse or idle.
// Ports:
//   clk, rst      in   clock, asynchronous active-high reset
//   en            in   global enable; 0 holds everything and drops new calls
//   stop          in   emergency stop; freezes FSM, target, dwell, count
//   call_req      in   per-floor call requests (bit i = floor i)
//   cur_floor     in   floor reported by the elevator core
//   target        out  floor the core is commanded towards
//   move_up       out  car commanded upward
//   move_down     out  car commanded downward
//   door_open     out  door held open
//   pending       out  latched calls not yet served
//   served_count  out  number of calls served, wraps at 16
// ----------------------------------------------------------------------------
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES = DWELL_DEFAULT
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                stop,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]  cur_floor,
    output logic [FLOOR_W-1:0]  target,
    output logic                move_up,
    output logic                move_down,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic [3:0]          served_count
);

    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL_CYCLES - 1);

    state_t               state, state_next;
    dir_t                 last_dir, last_dir_next;
    logic [FLOOR_W-1:0]   target_next;
    logic [DWELL_W-1:0]   dwell, dwell_next;
    logic [N_FLOORS-1:0]  clear_mask;
    logic [N_FLOORS-1:0]  cur_mask;
    logic                 serve;
    logic                 active;
    logic [FLOOR_W-1:0]   nearest_above, nearest_below;
    logic                 above_valid, below_valid;

    assign active   = en & ~stop;
    assign cur_mask = N_FLOORS'(1) << cur_floor;

    next_floor_select u_select (
        .pending       (pending),
        .cur_floor     (cur_floor),
        .nearest_above (nearest_above),
        .above_valid   (above_valid),
        .nearest_below (nearest_below),
        .below_valid   (below_valid)
    );

    // State register; state_next already equals state outside active cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath decisions. Everything defaults to "hold", so a
    // non-active cycle (en=0 or stop=1) changes nothing here.
    always_comb begin
        state_next    = state;
        target_next   = target;
        dwell_next    = dwell;
        last_dir_next = last_dir;
        clear_mask    = '0;
        serve         = 1'b0;
        if (active) begin
            unique case (state)
                ST_IDLE: begin
                    if ((pending & cur_mask) != '0) begin
                        clear_mask = cur_mask;
                        serve      = 1'b1;
                        dwell_next = DWELL_RELOAD;
                        state_next = ST_DOOR;
                    end else if (above_valid) begin
                        target_next   = nearest_above;
                        last_dir_next = DIR_UP;
                        state_next    = ST_MOVE_UP;
                    end else if (below_valid) begin
                        target_next   = nearest_below;
                        last_dir_next = DIR_DOWN;
                        state_next    = ST_MOVE_DOWN;
                    end
                end
                ST_MOVE_UP: begin
                    if (cur_floor == target) begin
                        clear_mask = cur_mask;
                        serve      = 1'b1;
                        dwell_next = DWELL_RELOAD;
                        state_next = ST_DOOR;
                    end else if (above_valid) begin
                        target_next = nearest_above;
                    end
                end
                ST_MOVE_DOWN: begin
                    if (cur_floor == target) begin
                        clear_mask = cur_mask;
                        serve      = 1'b1;
                        dwell_next = DWELL_RELOAD;
                        state_next = ST_DOOR;
                    end else if (below_valid) begin
                        target_next = nearest_below;
                    end
                end
                ST_DOOR: begin
                    // A call at the open floor is absorbed at once (raw
                    // call_req included) and restarts the dwell.
                    if (((pending | call_req) & cur_mask) != '0) begin
                        clear_mask = cur_mask;
                        serve      = 1'b1;
                        dwell_next = DWELL_RELOAD;
                    end else if (dwell != '0) begin
                        dwell_next = dwell - 1'b1;
                    end else if (last_dir == DIR_UP) begin
                        if (above_valid) begin
                            target_next = nearest_above;
                            state_next  = ST_MOVE_UP;
                        end else if (below_valid) begin
                            target_next   = nearest_below;
                            last_dir_next = DIR_DOWN;
                            state_next    = ST_MOVE_DOWN;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        if (below_valid) begin
                            target_next = nearest_below;
                            state_next  = ST_MOVE_DOWN;
                        end else if (above_valid) begin
                            target_next   = nearest_above;
                            last_dir_next = DIR_UP;
                            state_next    = ST_MOVE_UP;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath registers. The call latch runs whenever enabled (including
    // during stop); clearing the served floor wins over a same-cycle call.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= '0;
            target       <= '0;
            dwell        <= '0;
            last_dir     <= DIR_UP;
            served_count <= '0;
        end else begin
            if (en) begin
                pending <= (pending | call_req) & ~clear_mask;
            end
            target       <= target_next;
            dwell        <= dwell_next;
            last_dir     <= last_dir_next;
            served_count <= served_count + {3'b000, serve};
        end
    end

    // Motion and door commands decode straight from the state.
    always_comb begin
        move_up   = (state == ST_MOVE_UP);
        move_down = (state == ST_MOVE_DOWN);
        door_open = (state == ST_DOOR);
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// ----------------------------------------------------------------------------
// tb_elevator_call_scheduler
// Directed bench for elevator_call_scheduler (DWELL_CYCLES = 3). Inputs are
// driven 1 time unit after a rising edge and outputs are checked there too,
// so every check sees the state produced by the preceding edge.
// ----------------------------------------------------------------------------
module tb_elevator_call_scheduler;

    logic       clk;
    logic       rst;
    logic       en;
    logic       stop;
    logic [3:0] call_req;
    logic [1:0] cur_floor;
    logic [1:0] target;
    logic       move_up;
    logic       move_down;
    logic       door_open;
    logic [3:0] pending;
    logic [3:0] served_count;

    int checks = 0;
    int errors = 0;

    elevator_call_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .stop         (stop),
        .call_req     (call_req),
        .cur_floor    (cur_floor),
        .target       (target),
        .move_up      (move_up),
        .move_down    (move_down),
        .door_open    (door_open),
        .pending      (pending),
        .served_count (served_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic s,
                                 input logic [3:0] c, input logic [1:0] f);
        en        = e;
        stop      = s;
        call_req  = c;
        cur_floor = f;
    endtask

    // Compare all outputs at once against hand-computed expectations.
    task automatic checkOutput(input string tag, input logic [1:0] t,
                               input logic u, input logic d, input logic o,
                               input logic [3:0] p, input logic [3:0] s);
        checks++;
        assert ({target, move_up, move_down, door_open, pending, served_count}
                === {t, u, d, o, p, s})
        else begin
            errors++;
            $error("[TB] FAIL %s: observed tgt=%0d up=%b dn=%b door=%b pend=%b served=%0d, expected tgt=%0d up=%b dn=%b door=%b pend=%b served=%0d",
                   tag, target, move_up, move_down, door_open, pending, served_count,
                   t, u, d, o, p, s);
        end
    endtask

    // Linear directed sequence; expected values follow the scheduler rules.
    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 2'd0);
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_async", 2'd0, 0, 0, 0, 4'b0000, 4'd0);
        tick();
        rst = 1'b0;

        // Call to floor 3 from floor 0, travel, dwell, back to idle.
        applyStimulus(1, 0, 4'b1000, 2'd0); tick();
        checkOutput("latch_call3", 2'd0, 0, 0, 0, 4'b1000, 4'd0);
        applyStimulus(1, 0, 4'b0000, 2'd0); tick();
        checkOutput("start_up_t3", 2'd3, 1, 0, 0, 4'b1000, 4'd0);
        applyStimulus(1, 0, 4'b0000, 2'd1); tick();
        applyStimulus(1, 0, 4'b0000, 2'd3); tick();
        checkOutput("arrive3_door", 2'd3, 0, 0, 1, 4'b0000, 4'd1);
        tick(); tick();
        checkOutput("door3_last", 2'd3, 0, 0, 1, 4'b0000, 4'd1);
        tick();
        checkOutput("door3_idle", 2'd3, 0, 0, 0, 4'b0000, 4'd1);

        // En-route pickup: call floor 1 while heading for floor 3.
        applyStimulus(1, 0, 4'b1000, 2'd0); tick();
        applyStimulus(1, 0, 4'b0000, 2'd0); tick();
        applyStimulus(1, 0, 4'b0010, 2'd0); tick();
        applyStimulus(1, 0, 4'b0000, 2'd0); tick();
        checkOutput("retarget_1", 2'd1, 1, 0, 0, 4'b1010, 4'd1);
        applyStimulus(1, 0, 4'b0000, 2'd1); tick();
        checkOutput("serve_1", 2'd1, 0, 0, 1, 4'b1000, 4'd2);
        tick(); tick(); tick();
        checkOutput("resume_up_t3", 2'd3, 1, 0, 0, 4'b1000, 4'd2);
        applyStimulus(1, 0, 4'b0000, 2'd3); tick();
        checkOutput("serve_3", 2'd3, 0, 0, 1, 4'b0000, 4'd3);
        tick(); tick(); tick();
        checkOutput("idle_after_3", 2'd3, 0, 0, 0, 4'b0000, 4'd3);

        // Direction preference: door at floor 2 going up, calls at 0 and 3.
        applyStimulus(1, 0, 4'b0100, 2'd0); tick();
        applyStimulus(1, 0, 4'b0000, 2'd0); tick();
        applyStimulus(1, 0, 4'b1001, 2'd1); tick();
        applyStimulus(1, 0, 4'b0000, 2'd2); tick();
        checkOutput("door2_pend9", 2'd2, 0, 0, 1, 4'b1001, 4'd4);
        tick(); tick(); tick();
        checkOutput("exit_up_t3", 2'd3, 1, 0, 0, 4'b1001, 4'd4);
        applyStimulus(1, 0, 4'b0000, 2'd3); tick();
        tick(); tick(); tick();
        checkOutput("reverse_dn_t0", 2'd0, 0, 1, 0, 4'b0001, 4'd5);
        applyStimulus(1, 0, 4'b0000, 2'd0); tick();
        checkOutput("serve_0", 2'd0, 0, 0, 1, 4'b0000, 4'd6);
        tick(); tick(); tick();
        checkOutput("idle_at_0", 2'd0, 0, 0, 0, 4'b0000, 4'd6);

        // Emergency stop during dwell at floor 2 with a call to floor 0.
        applyStimulus(1, 0, 4'b0100, 2'd0); tick();
        applyStimulus(1, 0, 4'b0000, 2'd0); tick();
        applyStimulus(1, 0, 4'b0000, 2'd2); tick();
        tick();
        checkOutput("door2_dwell1", 2'd2, 0, 0, 1, 4'b0000, 4'd7);
        applyStimulus(1, 1, 4'b0001, 2'd2);
        repeat (5) tick();
        checkOutput("stop_frozen", 2'd2, 0, 0, 1, 4'b0001, 4'd7);
        applyStimulus(1, 0, 4'b0000, 2'd2); tick();
        checkOutput("stop_resume_door", 2'd2, 0, 0, 1, 4'b0001, 4'd7);
        tick();
        checkOutput("stop_exit_dn", 2'd0, 0, 1, 0, 4'b0001, 4'd7);

        // Disabled block ignores calls and holds everything.
        applyStimulus(0, 0, 4'b1111, 2'd1); tick(); tick();
        checkOutput("en_low_hold", 2'd0, 0, 1, 0, 4'b0001, 4'd7);

        // Call at the open floor during dwell: served and dwell restarts.
        applyStimulus(1, 0, 4'b0000, 2'd0); tick();
        checkOutput("serve_0_again", 2'd0, 0, 0, 1, 4'b0000, 4'd8);
        tick();
        applyStimulus(1, 0, 4'b0001, 2'd0); tick();
        checkOutput("door_recall", 2'd0, 0, 0, 1, 4'b0000, 4'd9);
        applyStimulus(1, 0, 4'b0000, 2'd0); tick(); tick();
        checkOutput("door_reload_held", 2'd0, 0, 0, 1, 4'b0000, 4'd9);
        tick();
        checkOutput("idle_after_reload", 2'd0, 0, 0, 0, 4'b0000, 4'd9);

        // Served count wrap: repeated calls at the current floor.
        applyStimulus(1, 0, 4'b0001, 2'd0); tick();
        checkOutput("idle_latch0", 2'd0, 0, 0, 0, 4'b0001, 4'd9);
        tick();
        checkOutput("idle_serve_cur", 2'd0, 0, 0, 1, 4'b0000, 4'd10);
        repeat (5) tick();
        checkOutput("count_15", 2'd0, 0, 0, 1, 4'b0000, 4'd15);
        tick();
        checkOutput("count_wrap0", 2'd0, 0, 0, 1, 4'b0000, 4'd0);
        applyStimulus(1, 0, 4'b0000, 2'd0); tick(); tick(); tick();
        checkOutput("idle_after_wrap", 2'd0, 0, 0, 0, 4'b0000, 4'd0);

        // Reset pulse in the middle of a downward move.
        applyStimulus(1, 0, 4'b0110, 2'd3); tick();
        applyStimulus(1, 0, 4'b0000, 2'd3); tick();
        checkOutput("down_t2", 2'd2, 0, 1, 0, 4'b0110, 4'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_mid_move", 2'd0, 0, 0, 0, 4'b0000, 4'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_reset_idle", 2'd0, 0, 0, 0, 4'b0000, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
